// File: rtl/xadc_drp_pkg.sv
// Shared types and constants for the XADC DRP scheduler: FSM states, requester
// identities, bus widths and the default scan-slot channel addresses.
package xadc_drp_pkg;

  localparam int DRP_AW   = 7;
  localparam int DRP_DW   = 16;
  localparam int SAMPLE_W = 12;
  localparam int SLOT_W   = 2;
  localparam int MAX_CH   = 1 << SLOT_W;

  localparam logic [DRP_AW-1:0] CH_ADDR0_DEF = 7'h13;  // VAUX3
  localparam logic [DRP_AW-1:0] CH_ADDR1_DEF = 7'h1B;  // VAUX11
  localparam logic [DRP_AW-1:0] CH_ADDR2_DEF = 7'h12;  // VAUX2
  localparam logic [DRP_AW-1:0] CH_ADDR3_DEF = 7'h1A;  // VAUX10

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {SCAN, HOST} req_t;

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s,
                                                  input int num_ch);
    return (int'(s) == num_ch - 1) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/xadc_ch_avg.sv
// Per-slot accumulator bank: sums 2^AVG_LOG2 codes per scan slot and emits the
// truncated mean combinationally in the cycle the last code is added.
module xadc_ch_avg
  import xadc_drp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                CLK100MHZ,
  input  logic                RESET,
  input  logic                add_en,
  input  logic [SLOT_W-1:0]   slot,
  input  logic [SAMPLE_W-1:0] code,
  output logic [SAMPLE_W-1:0] avg,
  output logic                avg_valid
);

  localparam int AW = SAMPLE_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc [MAX_CH];
  logic [CW-1:0] cnt [MAX_CH];
  logic [AW-1:0] sum;
  logic          last;

  always_comb begin
    sum       = acc[slot] + AW'(code);
    last      = (cnt[slot] == CNT_LAST);
    avg_valid = add_en && last;
    avg       = avg_valid ? SAMPLE_W'(sum >> AVG_LOG2) : '0;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (add_en) begin
      if (last) begin
        acc[slot] <= '0;
        cnt[slot] <= '0;
      end else begin
        acc[slot] <= sum;
        cnt[slot] <= cnt[slot] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sched.sv
// Sole owner of the XADC DRP port: scans aux channels on EOC, arbitrates host
// readback round-robin against the scan, and guards each read with a DRDY watchdog.
module xadc_drp_sched
  import xadc_drp_pkg::*;
#(
  parameter int                NUM_CH   = 4,
  parameter logic [DRP_AW-1:0] CH_ADDR0 = CH_ADDR0_DEF,
  parameter logic [DRP_AW-1:0] CH_ADDR1 = CH_ADDR1_DEF,
  parameter logic [DRP_AW-1:0] CH_ADDR2 = CH_ADDR2_DEF,
  parameter logic [DRP_AW-1:0] CH_ADDR3 = CH_ADDR3_DEF,
  parameter int                AVG_LOG2 = 2,
  parameter int                TIMEOUT  = 255
) (
  input  logic                CLK100MHZ,
  input  logic                RESET,
  input  logic                eoc,
  output logic                drp_den,
  output logic [DRP_AW-1:0]   drp_daddr,
  input  logic [DRP_DW-1:0]   drp_do,
  input  logic                drp_drdy,
  input  logic                host_req,
  input  logic [DRP_AW-1:0]   host_addr,
  output logic                host_gnt,
  output logic [DRP_DW-1:0]   host_data,
  output logic                host_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [SLOT_W-1:0]   sample_ch,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err,
  output state_t              dbg_state
);

  // Handshake: host_req is a level held until host_gnt; host_gnt and drp_den
  // pulse together; host_valid/sample_valid pulse once, data valid that cycle.
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  req_t                  cur, last_served;
  logic                  scan_pend, host_q, host_pend;
  logic                  pick_scan, pick_host, issue_scan, wd_expired, add_en;
  logic [SLOT_W-1:0]     slot;
  logic [WD_W-1:0]       wd;
  logic [SAMPLE_W-1:0]   code_q, avg;
  logic [DRP_AW-1:0]     slot_addr;
  logic                  avg_valid;

  // host_req is seen one edge late so it ties with a same-cycle eoc.
  assign host_pend  = host_req && host_q;
  assign pick_scan  = scan_pend && (!host_pend || last_served == HOST);
  assign pick_host  = host_pend && (!scan_pend || last_served == SCAN);
  assign issue_scan = (state == IDLE) && pick_scan;
  assign wd_expired = (state == WAIT) && !drp_drdy && (wd == WD_W'(TIMEOUT));

  always_comb begin
    case (slot)
      2'd0:    slot_addr = CH_ADDR0;
      2'd1:    slot_addr = CH_ADDR1;
      2'd2:    slot_addr = CH_ADDR2;
      default: slot_addr = CH_ADDR3;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_scan || pick_host) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (drp_drdy) state_nxt = DONE;
               else if (wd_expired) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    drp_den    = (state == ISSUE);
    host_gnt   = (state == ISSUE) && (cur == HOST);
    host_valid = (state == DONE) && (cur == HOST);
    add_en     = (state == DONE) && (cur == SCAN);
    busy       = (state != IDLE);
    dbg_state  = state;
    sample_valid = avg_valid;
    sample_data  = avg;
    sample_ch    = avg_valid ? slot : '0;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      scan_pend   <= 1'b0;
      host_q      <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      cur         <= SCAN;
      last_served <= HOST;
      drp_daddr   <= '0;
      slot        <= '0;
      wd          <= '0;
      code_q      <= '0;
      host_data   <= '0;
    end else begin
      host_q <= host_req;
      // A new eoc always wins over the clear, so one landing on issue stays pending.
      if (eoc) begin
        scan_pend <= 1'b1;
        if (scan_pend && !issue_scan) overrun <= 1'b1;
      end else if (issue_scan) begin
        scan_pend <= 1'b0;
      end
      if (state == IDLE && (pick_scan || pick_host)) begin
        cur         <= pick_scan ? SCAN : HOST;
        last_served <= pick_scan ? SCAN : HOST;
        drp_daddr   <= pick_scan ? slot_addr : host_addr;
      end
      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;
      if (state == WAIT && drp_drdy) begin
        code_q <= drp_do[DRP_DW-1:DRP_DW-SAMPLE_W];
        if (cur == HOST) host_data <= drp_do;
      end
      if (wd_expired) timeout_err <= 1'b1;
      if (cur == SCAN && (state == DONE || wd_expired)) slot <= next_slot(slot, NUM_CH);
    end
  end

  xadc_ch_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .add_en    (add_en),
    .slot      (slot),
    .code      (code_q),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Directed plus randomized bench for xadc_drp_sched: one averaging instance and
// one pass-through instance share stimulus and are checked against a reference model.
module tb_xadc_drp_sched;
  import xadc_drp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        eoc = 1'b0, host_req = 1'b0, drp_drdy = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] drp_do = '0;

  logic        den, gnt, hvalid, svalid, busy, ovr, tmo;
  logic [6:0]  daddr;
  logic [15:0] hdata;
  logic [11:0] sdata;
  logic [1:0]  sch;
  state_t      dbg;

  logic        z_den, z_gnt, z_hvalid, z_svalid, z_busy, z_ovr, z_tmo;
  logic [6:0]  z_daddr;
  logic [15:0] z_hdata;
  logic [11:0] z_sdata;
  logic [1:0]  z_sch;
  state_t      z_dbg;

  xadc_drp_sched #(.NUM_CH(4), .AVG_LOG2(2), .TIMEOUT(255)) dut (
    .CLK100MHZ(clk), .RESET(rst), .eoc(eoc), .drp_den(den), .drp_daddr(daddr),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .host_req(host_req), .host_addr(host_addr),
    .host_gnt(gnt), .host_data(hdata), .host_valid(hvalid), .sample_data(sdata),
    .sample_ch(sch), .sample_valid(svalid), .busy(busy), .overrun(ovr),
    .timeout_err(tmo), .dbg_state(dbg)
  );

  xadc_drp_sched #(.NUM_CH(4), .AVG_LOG2(0), .TIMEOUT(255)) dut0 (
    .CLK100MHZ(clk), .RESET(rst), .eoc(eoc), .drp_den(z_den), .drp_daddr(z_daddr),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .host_req(host_req), .host_addr(host_addr),
    .host_gnt(z_gnt), .host_data(z_hdata), .host_valid(z_hvalid), .sample_data(z_sdata),
    .sample_ch(z_sch), .sample_valid(z_svalid), .busy(z_busy), .overrun(z_ovr),
    .timeout_err(z_tmo), .dbg_state(z_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp0_q[$];
  logic [6:0]  addr_tab [4] = '{7'h13, 7'h1B, 7'h12, 7'h1A};
  int          m_slot;
  int          m_sum [4];
  int          m_n [4];
  bit          m_last_host;
  int          dut_samples = 0, z_samples = 0;
  logic [11:0] last_sample = '0, z_last = '0;
  logic [1:0]  last_ch = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_last_host = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0;
      m_n[i]   = 0;
    end
  endtask

  // A completed scan read: pass-through gets every code, averager every 4th.
  task automatic model_scan(input logic [15:0] v);
    int code;
    code = int'(v) / 16;
    exp0_q.push_back({2'(m_slot), 12'(code)});
    m_sum[m_slot] += code;
    m_n[m_slot]++;
    if (m_n[m_slot] == 4) begin
      exp_q.push_back({2'(m_slot), 12'(m_sum[m_slot] / 4)});
      m_sum[m_slot] = 0;
      m_n[m_slot]   = 0;
    end
    m_slot = (m_slot + 1) % 4;
  endtask

  always @(negedge clk) begin
    if (svalid) begin
      chk("dut_sample", {1'b1, sch, sdata},
          (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 15'h0);
      last_sample = sdata;
      last_ch     = sch;
      dut_samples++;
    end
    if (z_svalid) begin
      chk("pass_sample", {1'b1, z_sch, z_sdata},
          (exp0_q.size() != 0) ? {1'b1, exp0_q.pop_front()} : 15'h0);
      z_last = z_sdata;
      z_samples++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; eoc = 1'b0; host_req = 1'b0; drp_drdy = 1'b0; drp_do = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
  endtask

  task automatic expect_den(input bit is_host, input logic [6:0] addr);
    int k = 0;
    while (!den && k < 20) begin
      tick();
      k++;
    end
    chk("den_seen", den, 1);
    chk(is_host ? "gnt_host" : "gnt_scan", gnt, is_host);
    chk("daddr", daddr, addr);
    m_last_host = is_host;
  endtask

  task automatic respond(input logic [15:0] v, input int d, input bit is_host);
    repeat (d) tick();
    drp_drdy = 1'b1;
    drp_do   = v;
    if (!is_host) model_scan(v);
    tick();
    drp_drdy = 1'b0;
    drp_do   = 16'($urandom);
    chk("done_busy", busy, 1);
    chk("host_valid", hvalid, is_host);
    if (is_host) chk("host_data", hdata, v);
    else         chk("pass_valid", z_svalid, 1);
    tick();
  endtask

  task automatic scan_txn(input logic [15:0] v, input int d);
    pulse_eoc();
    expect_den(1'b0, addr_tab[m_slot]);
    respond(v, d, 1'b0);
  endtask

  task automatic host_txn(input logic [6:0] a, input logic [15:0] v, input int d);
    host_req  = 1'b1;
    host_addr = a;
    expect_den(1'b1, a);
    host_req = 1'b0;
    respond(v, d, 1'b1);
  endtask

  // ---------------- directed and random steps ----------------
  initial begin
    int nden;
    bit first_host;
    logic [6:0] ha;
    model_reset();
    repeat (3) tick();
    chk("rst_den", den, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_svalid", svalid, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_hvalid", hvalid, 0);
    chk("rst_hdata", hdata, 0);
    chk("rst_state", 32'(dbg), 32'(IDLE));
    rst = 1'b0;
    tick();

    // single eoc: den two cycles later, pass-through yields 0x800 on slot 0
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("lat_den_n1", den, 0);
    tick();
    chk("lat_den_n2", den, 1);
    expect_den(1'b0, 7'h13);
    respond(16'h8000, 3, 1'b0);
    chk("pass_first", z_last, 12'h800);
    chk("pass_count", z_samples, 1);

    // averaging over four slot-0 reads, slots cycling through the address table
    for (int i = 1; i < 16; i++) begin
      logic [15:0] v;
      v = ((i % 4) == 0) ? ((i == 12) ? 16'h8040 : 16'h8000) : 16'($urandom);
      scan_txn(v, $urandom_range(1, 6));
      if (i == 11) chk("avg_none_yet", dut_samples, 0);
      if (i == 12) begin
        chk("avg_count", dut_samples, 1);
        chk("avg_value", last_sample, 12'h801);
        chk("avg_ch", last_ch, 0);
      end
    end

    // host and eoc together after reset: scan first, then host
    apply_reset();
    host_req = 1'b1; host_addr = 7'h00; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    expect_den(1'b0, 7'h13);
    respond(16'($urandom), 2, 1'b0);
    expect_den(1'b1, 7'h00);
    host_req = 1'b0;
    respond(16'hA5C3, 3, 1'b1);

    // overrun: two eocs while a read is outstanding, only one extra scan
    pulse_eoc();
    expect_den(1'b0, addr_tab[m_slot]);
    tick(); tick();
    pulse_eoc();
    tick();
    chk("ovr_first", ovr, 0);
    pulse_eoc();
    chk("ovr_set", ovr, 1);
    respond(16'($urandom), 1, 1'b0);
    expect_den(1'b0, addr_tab[m_slot]);
    respond(16'($urandom), 2, 1'b0);
    nden = 0;
    repeat (12) begin
      tick();
      nden += int'(den);
    end
    chk("ovr_no_extra", nden, 0);
    chk("ovr_sticky", ovr, 1);

    // watchdog: no DRDY at all
    pulse_eoc();
    expect_den(1'b0, addr_tab[m_slot]);
    repeat (256) tick();
    chk("tmo_before", tmo, 0);
    chk("tmo_busy", busy, 1);
    tick();
    chk("tmo_set", tmo, 1);
    chk("tmo_busy_off", busy, 0);
    chk("tmo_state", 32'(dbg), 32'(IDLE));
    m_slot = (m_slot + 1) % 4;
    scan_txn(16'($urandom), 2);

    // reset while waiting for DRDY
    pulse_eoc();
    expect_den(1'b0, addr_tab[m_slot]);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_den", den, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_tmo", tmo, 0);
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    drp_drdy = 1'b1;
    drp_do   = 16'hFFF0;
    tick();
    drp_drdy = 1'b0;
    chk("late_drdy_svalid", svalid, 0);
    chk("late_drdy_pass", z_svalid, 0);
    chk("late_drdy_hvalid", hvalid, 0);
    chk("late_drdy_busy", busy, 0);

    // randomized traffic mix against the model
    repeat (40) begin
      ha = 7'($urandom);
      case ($urandom_range(0, 2))
        0: scan_txn(16'($urandom), $urandom_range(1, 8));
        1: host_txn(ha, 16'($urandom), $urandom_range(1, 8));
        default: begin
          first_host = !m_last_host;
          host_req = 1'b1; host_addr = ha; eoc = 1'b1;
          tick();
          eoc = 1'b0;
          if (first_host) begin
            expect_den(1'b1, ha);
            host_req = 1'b0;
            respond(16'($urandom), $urandom_range(1, 8), 1'b1);
            expect_den(1'b0, addr_tab[m_slot]);
            respond(16'($urandom), $urandom_range(1, 8), 1'b0);
          end else begin
            expect_den(1'b0, addr_tab[m_slot]);
            respond(16'($urandom), $urandom_range(1, 8), 1'b0);
            expect_den(1'b1, ha);
            host_req = 1'b0;
            respond(16'($urandom), $urandom_range(1, 8), 1'b1);
          end
        end
      endcase
    end

    repeat (4) tick();
    chk("avg_queue_drained", exp_q.size(), 0);
    chk("pass_queue_drained", exp0_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
